// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the PC fetch sequencer.
// Includes the FSM encoding, the redirect bundle and the PC step.
package pc_fetch_sequencer_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_EXEC  = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] EXC_VECTOR_DEF = 32'h8000_0180;
    localparam logic [XLEN-1:0] PC_STEP        = 32'd4;

    // Redirect request from the core, sampled together with ex_done
    typedef struct packed {
        logic            exc;
        logic            jump;
        logic [XLEN-1:0] jump_target;
        logic            branch_taken;
        logic [XLEN-1:0] branch_target;
    } redirect_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_target_mux.sv
// Next-PC priority select: exception, jump, taken branch, then PC+4.
// Misaligned jump/branch targets are redirected to the exception vector.
module pc_target_mux
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic [XLEN-1:0] pc_i,
    input  redirect_t       redir,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    always_comb begin
        target   = pc_i + PC_STEP;
        misalign = 1'b0;
        if (redir.exc) begin
            target = EXC_VECTOR;
        end else if (redir.jump) begin
            if (is_misaligned(redir.jump_target)) begin
                target   = EXC_VECTOR;
                misalign = 1'b1;
            end else begin
                target = redir.jump_target;
            end
        end else if (redir.branch_taken) begin
            if (is_misaligned(redir.branch_target)) begin
                target   = EXC_VECTOR;
                misalign = 1'b1;
            end else begin
                target = redir.branch_target;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multicycle fetch/issue/execute controller driving the PC register.
// Holds the FSM, the fetch timeout counter and the instruction latch.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int unsigned     TIMEOUT    = 16,
    parameter int unsigned     CNT_W      = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_we_o,
    output logic [XLEN-1:0] pc_next_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] instr_o,
    output logic            instr_valid_o,
    input  logic            stall_i,
    input  logic            ex_done_i,
    input  logic            exc_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            fetch_err_o,
    output logic            misalign_o
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic [XLEN-1:0]  instr_q, instr_d;

    redirect_t        redir;
    logic [XLEN-1:0]  target;
    logic             target_misalign;

    assign redir = '{
        exc:           exc_i,
        jump:          jump_i,
        jump_target:   jump_target_i,
        branch_taken:  branch_taken_i,
        branch_target: branch_target_i
    };

    pc_target_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_target_mux (
        .pc_i     (pc_i),
        .redir    (redir),
        .target   (target),
        .misalign (target_misalign)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            instr_q <= instr_d;
        end
    end

    assign instr_o     = instr_q;
    assign fetch_err_o = tmo_q;

    // Next state and outputs; the cycle after a timeout redirects the PC with the request dropped
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tmo_d         = 1'b0;
        instr_d       = instr_q;
        pc_we_o       = 1'b0;
        pc_next_o     = '0;
        misalign_o    = 1'b0;
        imem_req_o    = 1'b0;
        imem_addr_o   = pc_i;
        instr_valid_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (tmo_q) begin
                    pc_we_o   = 1'b1;
                    pc_next_o = EXC_VECTOR;
                    cnt_d     = '0;
                end else begin
                    imem_req_o = 1'b1;
                    if (imem_ack_i) begin
                        instr_d = imem_rdata_i;
                        cnt_d   = '0;
                        state_d = S_ISSUE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        tmo_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_ISSUE: begin
                instr_valid_o = 1'b1;
                state_d       = S_EXEC;
            end
            S_EXEC: begin
                if (ex_done_i && !stall_i) begin
                    pc_we_o    = 1'b1;
                    pc_next_o  = target;
                    misalign_o = target_misalign;
                    state_d    = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: vector table plus scoreboard
// queues for PC writes and issued instructions, with hand-written corner sequences.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] EXC      = 32'h8000_0180;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        int          dly;
        int          stalls;
        logic        exc;
        logic        jmp;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic [31:0] exp_next;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] next;
        logic        mis;
        logic        ferr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_reg;
    logic        pc_we_o;
    logic [31:0] pc_next_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        stall_i;
    logic        ex_done_i;
    logic        exc_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        fetch_err_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    exp_t        pcq[$];
    logic [31:0] iq[$];
    vec_t        vecs[12];
    vec_t        tv;

    pc_fetch_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .pc_i            (pc_reg),
        .pc_we_o         (pc_we_o),
        .pc_next_o       (pc_next_o),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .instr_o         (instr_o),
        .instr_valid_o   (instr_valid_o),
        .stall_i         (stall_i),
        .ex_done_i       (ex_done_i),
        .exc_i           (exc_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .fetch_err_o     (fetch_err_o),
        .misalign_o      (misalign_o)
    );

    always #5 clk = ~clk;

    // The PC register the sequencer drives
    always @(posedge clk or negedge rst) begin
        if (!rst) pc_reg <= RESET_PC;
        else if (pc_we_o) pc_reg <= pc_next_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every PC write and every issue pulse must be expected
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] ei;
        #2;
        if (rst) begin
            if (pc_we_o) begin
                if (pcq.size() == 0) begin
                    chk1("unexpected_pc_we", pc_we_o, 1'b0);
                end else begin
                    e = pcq.pop_front();
                    chk("pc_next", pc_next_o, e.next);
                    chk1("misalign", misalign_o, e.mis);
                    chk1("fetch_err", fetch_err_o, e.ferr);
                end
            end else begin
                if (misalign_o) chk1("stray_misalign", misalign_o, 1'b0);
                if (fetch_err_o) chk1("stray_fetch_err", fetch_err_o, 1'b0);
            end
            if (instr_valid_o) begin
                if (iq.size() == 0) begin
                    chk1("unexpected_instr_valid", instr_valid_o, 1'b0);
                end else begin
                    ei = iq.pop_front();
                    chk("instr", instr_o, ei);
                end
            end
        end
    end

    task automatic clear_redirect();
        ex_done_i       = 1'b0;
        stall_i         = 1'b0;
        exc_i           = 1'b0;
        jump_i          = 1'b0;
        jump_target_i   = '0;
        branch_taken_i  = 1'b0;
        branch_target_i = '0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req_o) chk1("req_wait_timeout", imem_req_o, 1'b1);
    endtask

    // Acks after dly request cycles; leaves ack high for the current cycle
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] rdata, input int dly);
        wait_req();
        chk("imem_addr", imem_addr_o, addr);
        repeat (dly) @(negedge clk);
        imem_ack_i   = 1'b1;
        imem_rdata_i = rdata;
        iq.push_back(rdata);
    endtask

    task automatic run_vec(input vec_t v);
        do_fetch(v.addr, v.rdata, v.dly);
        @(negedge clk);
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'hDEAD_BEEF;
        chk1("instr_valid", instr_valid_o, 1'b1);
        ex_done_i = 1'b1;
        for (int s = 0; s < v.stalls; s++) begin
            @(negedge clk);
            ex_done_i = 1'b1;
            stall_i   = 1'b1;
            exc_i     = 1'b1;
        end
        @(negedge clk);
        stall_i         = 1'b0;
        ex_done_i       = 1'b1;
        exc_i           = v.exc;
        jump_i          = v.jmp;
        jump_target_i   = v.jt;
        branch_taken_i  = v.br;
        branch_target_i = v.bt;
        pcq.push_back('{next: v.exp_next, mis: v.exp_mis, ferr: 1'b0});
        @(negedge clk);
        clear_redirect();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //          addr          rdata         dly stl exc jmp jt            br   bt            exp_next      mis
        vecs[0]  = '{32'h0040_0000, 32'h2008_0005, 0, 0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0040_0004, 1'b0};
        vecs[1]  = '{32'h0040_0004, 32'h1111_1111, 0, 0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0040_0008, 1'b0};
        vecs[2]  = '{32'h0040_0008, 32'h2222_2222, 2, 0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0040_000C, 1'b0};
        vecs[3]  = '{32'h0040_000C, 32'h3333_3333, 0, 0, 1'b0, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0200, 32'h0040_0100, 1'b0};
        vecs[4]  = '{32'h0040_0100, 32'h4444_4444, 0, 0, 1'b1, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0200, EXC,           1'b0};
        vecs[5]  = '{EXC,           32'h5555_5555, 0, 0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0102, EXC,           1'b1};
        vecs[6]  = '{EXC,           32'h6666_6666, 1, 0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0040, 32'h0040_0040, 1'b0};
        vecs[7]  = '{32'h0040_0040, 32'h7777_0000, 0, 0, 1'b0, 1'b1, 32'h0040_0043, 1'b0, 32'h0,         EXC,           1'b1};
        vecs[8]  = '{EXC,           32'h8888_8888, 15, 5, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         32'h8000_0184, 1'b0};
        vecs[9]  = '{32'h8000_0184, 32'h9999_9999, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'hFFFF_FFFC, 1'b0};
        vecs[10] = '{32'hFFFF_FFFC, 32'hAAAA_AAAA, 0, 0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0000, 1'b0};
        vecs[11] = '{32'h0000_0000, 32'hBBBB_BBBB, 0, 0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         EXC,           1'b0};

        rst          = 1'b0;
        imem_ack_i   = 1'b0;
        imem_rdata_i = '0;
        clear_redirect();

        repeat (2) @(negedge clk);
        #1;
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc_next", pc_next_o, 32'h0);
        chk1("rst_pc_we", pc_we_o, 1'b0);
        chk1("rst_req", imem_req_o, 1'b0);
        chk1("rst_instr_valid", instr_valid_o, 1'b0);
        chk1("rst_fetch_err", fetch_err_o, 1'b0);
        chk1("rst_misalign", misalign_o, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        chk1("idle_no_req", imem_req_o, 1'b0);
        @(negedge clk);
        chk1("first_req_latency", imem_req_o, 1'b1);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Fetch timeout: no ack for 16 request cycles
        wait_req();
        chk("tmo_addr", imem_addr_o, EXC);
        repeat (15) @(negedge clk);
        pcq.push_back('{next: EXC, mis: 1'b0, ferr: 1'b1});
        @(negedge clk);
        chk1("tmo_fetch_err", fetch_err_o, 1'b1);
        chk1("tmo_pc_we", pc_we_o, 1'b1);
        @(negedge clk);
        chk1("tmo_err_single", fetch_err_o, 1'b0);
        chk1("tmo_refetch_req", imem_req_o, 1'b1);
        tv = '{EXC, 32'hC0DE_0001, 0, 1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h8000_0184, 1'b0};
        run_vec(tv);

        // Asynchronous reset while a fetch is outstanding
        wait_req();
        #3;
        rst = 1'b0;
        #1;
        chk1("arst_req_drop", imem_req_o, 1'b0);
        chk1("arst_no_pc_we", pc_we_o, 1'b0);
        chk("arst_instr", instr_o, 32'h0);
        pcq.delete();
        iq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk1("rerst_idle", imem_req_o, 1'b0);
        @(negedge clk);
        chk1("rerst_first_req", imem_req_o, 1'b1);
        run_vec(vecs[0]);

        repeat (3) @(negedge clk);
        chk("pcq_drained", 32'(pcq.size()), 32'h0);
        chk("iq_drained", 32'(iq.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
